mem_copy_master: RTL and testbench

MEM_COPY_MASTER -- requirements
Module: mem_copy_master

---
 rtl/mem_copy_master.sv | 158 +++++++++++++++
 tb/tb_mem_copy_master.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_master.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : mem_copy_master
// Description : Bus master that copies a block of words from one memory
//               address range to another. Each word takes three cycles:
//               RD (issue read), RDW (capture read data), WR (write it out).
//               Outputs are decoded purely from registered state, so no
//               input reaches an output combinationally.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
// Ports
//   clk        in   1       rising-edge clock
//   reset      in   1       asynchronous active-high reset
//   start      in   1       begin a copy (sampled in IDLE only)
//   abort      in   1       cancel an active copy (RD/RDW/WR)
//   src_addr   in   ADDR_W  first source word address
//   dst_addr   in   ADDR_W  first destination word address
//   count      in   ADDR_W  number of words to copy
//   read_data  in   DATA_W  bus read data (valid while mem_cmd = MREAD)
//   mem_cmd    out  2       00 = NONE, 01 = READ, 10 = WRITE
//   mem_addr   out  ADDR_W  bus address
//   write_data out  DATA_W  bus write data
//   busy       out  1       high whenever not IDLE
//   done       out  1       single-cycle completion pulse
//------------------------------------------------------------------------------
module mem_copy_master #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 9
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [ADDR_W-1:0] count,
   input  logic [DATA_W-1:0] read_data,
   output logic [1:0]        mem_cmd,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] write_data,
   output logic              busy,
   output logic              done
);

   localparam logic [1:0] C_MNONE  = 2'b00;
   localparam logic [1:0] C_MREAD  = 2'b01;
   localparam logic [1:0] C_MWRITE = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD   = 3'd1,
      S_RDW  = 3'd2,
      S_WR   = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [ADDR_W-1:0] r_src;
   logic [ADDR_W-1:0] r_dst;
   logic [ADDR_W-1:0] r_rem;
   logic [DATA_W-1:0] r_data;
   logic [ADDR_W-1:0] w_rem_dec;

   // Remaining count after the word currently being written.
   assign w_rem_dec = r_rem - ADDR_W'(1);

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Datapath registers: latched parameters, running pointers, data word.
   // Address arithmetic wraps naturally at ADDR_W bits.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_src  <= '0;
         r_dst  <= '0;
         r_rem  <= '0;
         r_data <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_src <= src_addr;
                  r_dst <= dst_addr;
                  r_rem <= count;
               end
            end
            S_RDW: begin
               r_data <= read_data;
            end
            S_WR: begin
               r_src <= r_src + ADDR_W'(1);
               r_dst <= r_dst + ADDR_W'(1);
               r_rem <= w_rem_dec;
            end
            default: begin
            end
         endcase
      end
   end

   // Next-state and Moore output decode. Outputs depend only on r_state
   // and datapath registers; inputs only steer w_next.
   always_comb begin
      w_next     = r_state;
      mem_cmd    = C_MNONE;
      mem_addr   = '0;
      write_data = '0;
      busy       = 1'b1;
      done       = 1'b0;
      case (r_state)
         S_IDLE: begin
            busy = 1'b0;
            // abort is meaningless here; start wins when both are high
            if (start) begin
               w_next = (count != '0) ? S_RD : S_DONE;
            end
         end
         S_RD: begin
            mem_cmd  = C_MREAD;
            mem_addr = r_src;
            w_next   = abort ? S_IDLE : S_RDW;
         end
         S_RDW: begin
            mem_cmd  = C_MREAD;
            mem_addr = r_src;
            w_next   = abort ? S_IDLE : S_WR;
         end
         S_WR: begin
            // The write presented this cycle completes even when aborting.
            mem_cmd    = C_MWRITE;
            mem_addr   = r_dst;
            write_data = r_data;
            if (abort) begin
               w_next = S_IDLE;
            end else begin
               w_next = (w_rem_dec != '0) ? S_RD : S_DONE;
            end
         end
         S_DONE: begin
            done   = 1'b1;
            w_next = S_IDLE;
         end
         default: begin
            busy   = 1'b0;
            w_next = S_IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_copy_master.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_mem_copy_master
// Description : Self-checking bench for mem_copy_master. A word-addressed
//               memory with one-cycle read latency is attached to the bus;
//               expected bus activity and final memory contents come from a
//               word-by-word copy model over a reference array.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_mem_copy_master;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 9;
   localparam int DEPTH  = 1 << ADDR_W;

   localparam logic [1:0] C_MNONE  = 2'b00;
   localparam logic [1:0] C_MREAD  = 2'b01;
   localparam logic [1:0] C_MWRITE = 2'b10;

   logic              clk;
   logic              reset;
   logic              start;
   logic              abort;
   logic [ADDR_W-1:0] src_addr;
   logic [ADDR_W-1:0] dst_addr;
   logic [ADDR_W-1:0] count;
   logic [DATA_W-1:0] read_data;
   logic [1:0]        mem_cmd;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] write_data;
   logic              busy;
   logic              done;

   logic [DATA_W-1:0] mem     [DEPTH];
   logic [DATA_W-1:0] ref_mem [DEPTH];

   int n_checks;
   int n_errors;
   int wr_seen;

   mem_copy_master #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
   ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .abort      (abort),
      .src_addr   (src_addr),
      .dst_addr   (dst_addr),
      .count      (count),
      .read_data  (read_data),
      .mem_cmd    (mem_cmd),
      .mem_addr   (mem_addr),
      .write_data (write_data),
      .busy       (busy),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: bus command seen before the edge is applied to the memory
   // after it, giving the one-cycle registered read latency.
   task automatic step();
      logic [1:0]        c;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] wd;
      c  = mem_cmd;
      a  = mem_addr;
      wd = write_data;
      @(posedge clk);
      #1;
      if (c == C_MWRITE) begin
         mem[a] = wd;
         wr_seen++;
      end
      if (c == C_MREAD) begin
         read_data = mem[a];
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_cmd"},  32'(mem_cmd),    32'(C_MNONE));
      check({tag, "_addr"}, 32'(mem_addr),   32'h0);
      check({tag, "_wd"},   32'(write_data), 32'h0);
      check({tag, "_busy"}, 32'(busy),       32'h0);
      check({tag, "_done"}, 32'(done),       32'h0);
   endtask

   task automatic check_mem(input string tag);
      int mism;
      mism = 0;
      for (int i = 0; i < DEPTH; i++) begin
         if (mem[i] !== ref_mem[i]) mism++;
      end
      check({tag, "_mem"}, 32'(mism), 32'h0);
   endtask

   // Launch a copy and follow it cycle by cycle. abort_k / restart_k give
   // the cycle offset (from the first RD cycle) at which abort or a second
   // start is raised; -1 disables. ab_start raises abort together with start.
   task automatic run_copy(input string tag, input logic [ADDR_W-1:0] s,
                           input logic [ADDR_W-1:0] d, input logic [ADDR_W-1:0] n,
                           input int abort_k, input int restart_k, input bit ab_start);
      int                total;
      int                exp_wr;
      int                wr0;
      int                done_seen;
      bit                aborted;
      logic [ADDR_W-1:0] ra;
      logic [ADDR_W-1:0] wa;
      logic [DATA_W-1:0] v;
      total   = 3 * int'(n);
      exp_wr  = 0;
      aborted = 1'b0;
      wr0     = wr_seen;
      src_addr = s;
      dst_addr = d;
      count    = n;
      start    = 1'b1;
      abort    = ab_start;
      step();
      start    = 1'b0;
      abort    = 1'b0;
      src_addr = ADDR_W'($urandom);
      dst_addr = ADDR_W'($urandom);
      count    = ADDR_W'($urandom);
      for (int k = 0; k < total; k++) begin
         ra = s + ADDR_W'(k / 3);
         wa = d + ADDR_W'(k / 3);
         check({tag, "_busy"}, 32'(busy), 32'h1);
         check({tag, "_done_early"}, 32'(done), 32'h0);
         if (k % 3 != 2) begin
            check({tag, "_rdcmd"},  32'(mem_cmd),  32'(C_MREAD));
            check({tag, "_rdaddr"}, 32'(mem_addr), 32'(ra));
         end else begin
            v = ref_mem[ra];
            check({tag, "_wrcmd"},  32'(mem_cmd),    32'(C_MWRITE));
            check({tag, "_wraddr"}, 32'(mem_addr),   32'(wa));
            check({tag, "_wrdata"}, 32'(write_data), 32'(v));
            ref_mem[wa] = v;
            exp_wr++;
         end
         if (k == restart_k) begin
            start    = 1'b1;
            src_addr = ADDR_W'($urandom);
            dst_addr = ADDR_W'($urandom);
            count    = ADDR_W'($urandom_range(1, 20));
         end
         if (k == abort_k) abort = 1'b1;
         step();
         start = 1'b0;
         if (abort) begin
            abort   = 1'b0;
            aborted = 1'b1;
            break;
         end
      end
      if (aborted) begin
         check_idle({tag, "_abort"});
         done_seen = 0;
         for (int i = 0; i < 4; i++) begin
            step();
            if (done || busy) done_seen++;
         end
         check({tag, "_quiet"}, 32'(done_seen), 32'h0);
      end else begin
         check({tag, "_done"},    32'(done),    32'h1);
         check({tag, "_dbusy"},   32'(busy),    32'h1);
         check({tag, "_dcmd"},    32'(mem_cmd), 32'(C_MNONE));
         step();
         check_idle({tag, "_end"});
      end
      check({tag, "_nwr"}, 32'(wr_seen - wr0), 32'(exp_wr));
      check_mem(tag);
   endtask

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      wr_seen   = 0;
      reset     = 1'b1;
      start     = 1'b0;
      abort     = 1'b0;
      src_addr  = '0;
      dst_addr  = '0;
      count     = '0;
      read_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         mem[i]     = DATA_W'($urandom);
         ref_mem[i] = mem[i];
      end
      #1;
      check_idle("reset_async");
      step();
      step();
      reset = 1'b0;
      step();
      check_idle("reset_rel");

      // Basic three-word copy with fixed contents
      mem[9'h010] = 16'hAAAA; ref_mem[9'h010] = 16'hAAAA;
      mem[9'h011] = 16'hBBBB; ref_mem[9'h011] = 16'hBBBB;
      mem[9'h012] = 16'hCCCC; ref_mem[9'h012] = 16'hCCCC;
      run_copy("basic", 9'h010, 9'h020, 9'd3, -1, -1, 1'b0);
      check("basic_w0", 32'(mem[9'h020]), 32'hAAAA);
      check("basic_w1", 32'(mem[9'h021]), 32'hBBBB);
      check("basic_w2", 32'(mem[9'h022]), 32'hCCCC);

      // Zero-length copy, with abort raised alongside start
      run_copy("zero", 9'h055, 9'h066, 9'd0, -1, -1, 1'b1);

      // Address wrap on the source side
      run_copy("wrap", 9'h1FF, 9'h0FE, 9'd2, -1, -1, 1'b0);

      // Abort in the second word's RDW cycle
      run_copy("abort", 9'h030, 9'h040, 9'd4, 4, -1, 1'b0);

      // Abort in a WR cycle: that write still lands
      run_copy("abort_wr", 9'h070, 9'h080, 9'd3, 5, -1, 1'b0);

      // Restart while busy is ignored
      run_copy("restart", 9'h090, 9'h0A0, 9'd2, -1, 1, 1'b0);

      // Overlapping ranges, destination above source
      run_copy("overlap", 9'h100, 9'h102, 9'd5, -1, -1, 1'b0);

      // Asynchronous reset between edges during WR
      src_addr = 9'h0C0;
      dst_addr = 9'h0D0;
      count    = 9'd3;
      start    = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      check("rst_wr_cmd", 32'(mem_cmd), 32'(C_MWRITE));
      #2;
      reset = 1'b1;
      #1;
      check_idle("rst_mid");
      #2;
      reset = 1'b0;
      for (int i = 0; i < 4; i++) step();
      check_idle("rst_after");
      check_mem("rst");

      // Randomized copies
      for (int t = 0; t < 12; t++) begin
         logic [ADDR_W-1:0] rs;
         logic [ADDR_W-1:0] rd;
         logic [ADDR_W-1:0] rn;
         int                ak;
         int                rk;
         rs = ADDR_W'($urandom);
         rd = ADDR_W'($urandom);
         rn = ADDR_W'($urandom_range(0, 8));
         ak = -1;
         rk = -1;
         if (rn != 0 && $urandom_range(0, 3) == 0) ak = int'($urandom_range(0, 3 * int'(rn) - 1));
         if (rn != 0 && $urandom_range(0, 3) == 0) rk = int'($urandom_range(0, 3 * int'(rn) - 1));
         run_copy($sformatf("rand%0d", t), rs, rd, rn, ak, rk, 1'($urandom_range(0, 1)));
         for (int i = 0; i < int'($urandom_range(0, 2)); i++) step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
